// File: rtl/ctrl_scoreboard_pkg.sv
// Shared types and constants for the front-end RAW scoreboard and redirect/flush controller.
package ctrl_scoreboard_pkg;

  localparam int NB_GPR        = 32;
  localparam int RF_ADDR_WIDTH = $clog2(NB_GPR);
  localparam int MAX_RD_PORTS  = 4;
  localparam int MAX_WB_PORTS  = 2;
  // Wide enough to count every writeback port hitting one register in the same cycle.
  localparam int DEC_WIDTH     = $clog2(MAX_WB_PORTS + 1);

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_PEND  = 2'd1,
    FL_GUARD = 2'd2
  } flush_state_e;

endpackage

// File: rtl/ctrl_scoreboard_if.sv
// Bundle between decode/exe/writeback and the scoreboard controller.
interface ctrl_scoreboard_if
  import ctrl_scoreboard_pkg::*;
#(
  parameter int NbGpr       = NB_GPR,
  parameter int NbReadPorts = 2,
  parameter int NbWbPorts   = 1
);
  localparam int AW = $clog2(NbGpr);

  // Issue handshake: an instruction issues in exactly the cycle where
  // issue_valid_i and issue_ready_o are both high; ready never looks at valid.
  logic                        issue_valid_i;
  logic                        issue_ready_o;
  logic [AW-1:0]               issue_rd_i;
  logic [NbReadPorts*AW-1:0]   rs_i;
  logic [NbReadPorts-1:0]      rs_dirty_o;

  logic [NbWbPorts-1:0]        wb_valid_i;
  logic [NbWbPorts*AW-1:0]     wb_rd_i;

  logic                        redirect_req_i;
  logic                        mem_ready_i;
  logic                        fetch_hit_i;

  logic                        softresetn_o;
  logic                        pc_en_o;
  logic                        busy_o;
  logic                        err_o;
  flush_state_e                fl_state_o;

  modport master (
    output issue_valid_i, issue_rd_i, rs_i, wb_valid_i, wb_rd_i,
           redirect_req_i, mem_ready_i, fetch_hit_i,
    input  issue_ready_o, rs_dirty_o, softresetn_o, pc_en_o, busy_o, err_o, fl_state_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, rs_i, wb_valid_i, wb_rd_i,
           redirect_req_i, mem_ready_i, fetch_hit_i,
    output issue_ready_o, rs_dirty_o, softresetn_o, pc_en_o, busy_o, err_o, fl_state_o
  );

endinterface

// File: rtl/ctrl_scoreboard_gpr_busy_cnt.sv
// Pending-write counter for one GPR: saturating add, clamp-to-zero on underflow.
module gpr_busy_cnt
  import ctrl_scoreboard_pkg::*;
#(
  parameter int BusyWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc,
  input  logic [DEC_WIDTH-1:0] dec,
  output logic [BusyWidth-1:0] cnt,
  output logic                 underflow
);

  localparam int SW = BusyWidth + DEC_WIDTH;
  localparam logic [SW-1:0] CntMax = SW'({BusyWidth{1'b1}});

  logic [SW-1:0]        sum;
  logic [SW-1:0]        dec_ext;
  logic [SW-1:0]        diff;
  logic [BusyWidth-1:0] cnt_d;

  always_comb begin
    sum       = SW'(cnt) + SW'(inc);
    dec_ext   = SW'(dec);
    diff      = sum - dec_ext;
    underflow = (dec_ext > sum);
    cnt_d     = cnt;
    if (underflow) begin
      cnt_d = '0;
    end else if (diff > CntMax) begin
      cnt_d = CntMax[BusyWidth-1:0];
    end else begin
      cnt_d = diff[BusyWidth-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_scoreboard.sv
// Multi-port RAW scoreboard with saturation back-pressure and a redirect/flush FSM.
module ctrl_scoreboard
  import ctrl_scoreboard_pkg::*;
#(
  parameter int NbGpr       = NB_GPR,
  parameter int BusyWidth   = 2,
  parameter int NbReadPorts = 2,
  parameter int NbWbPorts   = 1,
  parameter int WbBypass    = 0
) (
  input logic          clk_i,
  input logic          rst_i,
  ctrl_scoreboard_if.slave bus
);

  localparam int AW = $clog2(NbGpr);
  localparam int CW = BusyWidth + DEC_WIDTH;
  localparam logic [BusyWidth-1:0] CntMax = '1;

  logic [BusyWidth-1:0] cnt      [NbGpr];
  logic [DEC_WIDTH-1:0] dec_cnt  [NbGpr];
  logic                 inc      [NbGpr];
  logic                 uflow    [NbGpr];
  logic [AW-1:0]        rs_idx   [NbReadPorts];
  logic [NbReadPorts-1:0] rs_dirty;

  logic         flush;
  logic         issue_ready;
  logic         issue_fire;
  logic         rd_sat;
  logic         busy;
  logic         any_uflow;
  logic         err_q;
  flush_state_e state_q;
  flush_state_e state_d;

  // x0 never carries a pending write.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  for (genvar r = 1; r < NbGpr; r++) begin : g_cnt
    gpr_busy_cnt #(.BusyWidth(BusyWidth)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc       (inc[r]),
      .dec       (dec_cnt[r]),
      .cnt       (cnt[r]),
      .underflow (uflow[r])
    );
  end

  for (genvar k = 0; k < NbReadPorts; k++) begin : g_rs
    assign rs_idx[k] = bus.rs_i[k*AW +: AW];
  end

  // Issue side: stall only when the destination counter is full or a flush is under way.
  always_comb begin
    rd_sat      = (bus.issue_rd_i != '0) && (cnt[bus.issue_rd_i] == CntMax);
    issue_ready = !flush && !rd_sat;
    issue_fire  = bus.issue_valid_i && issue_ready;
  end

  always_comb begin
    for (int r = 0; r < NbGpr; r++) begin
      inc[r]     = 1'b0;
      dec_cnt[r] = '0;
      if (r != 0) begin
        inc[r] = issue_fire && (bus.issue_rd_i == AW'(r));
        for (int p = 0; p < NbWbPorts; p++) begin
          if (bus.wb_valid_i[p] && (bus.wb_rd_i[p*AW +: AW] == AW'(r))) begin
            dec_cnt[r] = dec_cnt[r] + DEC_WIDTH'(1);
          end
        end
      end
    end
  end

  // A source retiring its last pending write this cycle reads clean when bypass is enabled.
  always_comb begin
    rs_dirty = '0;
    for (int k = 0; k < NbReadPorts; k++) begin
      if ((rs_idx[k] != '0) && (cnt[rs_idx[k]] != '0)) begin
        rs_dirty[k] = 1'b1;
      end
      if ((WbBypass != 0) && (CW'(cnt[rs_idx[k]]) == CW'(dec_cnt[rs_idx[k]]))) begin
        rs_dirty[k] = 1'b0;
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    any_uflow = 1'b0;
    for (int r = 0; r < NbGpr; r++) begin
      busy      = busy | (cnt[r] != '0);
      any_uflow = any_uflow | uflow[r];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (any_uflow) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // GUARD swallows the cycle after a flush so a lingering request cannot flush twice.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      FL_IDLE: begin
        if (bus.redirect_req_i) begin
          if (bus.mem_ready_i) begin
            flush   = 1'b1;
            state_d = FL_GUARD;
          end else begin
            state_d = FL_PEND;
          end
        end
      end
      FL_PEND: begin
        if (!bus.redirect_req_i) begin
          state_d = FL_IDLE;
        end else if (bus.mem_ready_i) begin
          flush   = 1'b1;
          state_d = FL_GUARD;
        end
      end
      FL_GUARD: state_d = FL_IDLE;
      default:  state_d = FL_IDLE;
    endcase
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.rs_dirty_o    = rs_dirty;
  assign bus.softresetn_o  = !flush;
  assign bus.pc_en_o       = bus.fetch_hit_i | flush;
  assign bus.busy_o        = busy;
  assign bus.err_o         = err_q;
  assign bus.fl_state_o    = state_q;

endmodule

// File: tb/tb_ctrl_scoreboard.sv
// Cycle-by-cycle vector bench for ctrl_scoreboard with two WB ports and WB bypass enabled.
`timescale 1ns/100ps
module tb_ctrl_scoreboard;
  import ctrl_scoreboard_pkg::*;

  typedef struct {
    logic       iv;
    logic [4:0] ird;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] wbv;
    logic [4:0] wr0;
    logic [4:0] wr1;
    logic       req;
    logic       mr;
    logic       fh;
    logic [6:0] exp;  // {issue_ready, rs_dirty[1:0], softresetn, pc_en, busy, err}
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  logic [6:0] exp_q[$];
  vec_t tbl[$];

  ctrl_scoreboard_if #(.NbGpr(32), .NbReadPorts(2), .NbWbPorts(2)) bus ();

  ctrl_scoreboard #(
    .NbGpr(32), .BusyWidth(2), .NbReadPorts(2), .NbWbPorts(2), .WbBypass(1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic iv, int ird, int rs0, int rs1, logic [1:0] wbv,
                              int wr0, int wr1, logic req, logic mr, logic fh,
                              logic [6:0] exp);
    vec_t v;
    v.iv = iv; v.ird = 5'(ird); v.rs0 = 5'(rs0); v.rs1 = 5'(rs1);
    v.wbv = wbv; v.wr0 = 5'(wr0); v.wr1 = 5'(wr1);
    v.req = req; v.mr = mr; v.fh = fh; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid_i  = v.iv;
    bus.issue_rd_i     = v.ird;
    bus.rs_i           = {v.rs1, v.rs0};
    bus.wb_valid_i     = v.wbv;
    bus.wb_rd_i        = {v.wr1, v.wr0};
    bus.redirect_req_i = v.req;
    bus.mem_ready_i    = v.mr;
    bus.fetch_hit_i    = v.fh;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // scoreboard: expectation queued with the stimulus, popped when outputs are sampled
  task automatic apply(input vec_t v, input int idx);
    logic [6:0] got;
    logic [6:0] want;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v.exp);
    #1;
    got  = {bus.issue_ready_o, bus.rs_dirty_o, bus.softresetn_o, bus.pc_en_o,
            bus.busy_o, bus.err_o};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL vec%0d: got {rdy,dirty,srn,pc,busy,err}=%b expected %b", idx, got, want);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //          iv rd rs0 rs1 wbv   w0 w1 req mr fh  exp
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 0 reset state
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 7'b1001000)); // 1 no fetch hit
    tbl.push_back(mk(1, 5, 5, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 2 issue rd5
    tbl.push_back(mk(0, 0, 5, 5, 2'b00, 0, 0, 0, 0, 1, 7'b1111110)); // 3 x5 dirty
    tbl.push_back(mk(0, 0, 5, 0, 2'b01, 5, 0, 0, 0, 1, 7'b1001110)); // 4 wb5 bypass
    tbl.push_back(mk(0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 5 x5 clean
    tbl.push_back(mk(1, 3, 3, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 6 issue rd3 #1
    tbl.push_back(mk(1, 3, 3, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1011110)); // 7 issue rd3 #2
    tbl.push_back(mk(1, 3, 3, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1011110)); // 8 issue rd3 #3
    tbl.push_back(mk(1, 3, 3, 0, 2'b00, 0, 0, 0, 0, 1, 7'b0011110)); // 9 saturated
    tbl.push_back(mk(1, 3, 3, 0, 2'b01, 3, 0, 0, 0, 1, 7'b0011110)); // 10 sat + wb3
    tbl.push_back(mk(0, 3, 3, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1011110)); // 11 ready again
    tbl.push_back(mk(0, 0, 3, 0, 2'b11, 3, 3, 0, 0, 1, 7'b1001110)); // 12 dual wb drain
    tbl.push_back(mk(1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 13 issue rd7
    tbl.push_back(mk(1, 7, 7, 0, 2'b01, 7, 0, 0, 0, 1, 7'b1001110)); // 14 issue+wb rd7
    tbl.push_back(mk(0, 0, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1011110)); // 15 x7 still pending
    tbl.push_back(mk(0, 0, 7, 0, 2'b01, 7, 0, 0, 0, 1, 7'b1001110)); // 16 cnt7 was 1
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 7'b1001100)); // 17 x0 issue+wb
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100)); // 18 no err from x0
    tbl.push_back(mk(0, 0, 9, 0, 2'b01, 9, 0, 0, 0, 1, 7'b1001100)); // 19 wb clean x9
    tbl.push_back(mk(0, 0, 9, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001101)); // 20 err sticky
    tbl.push_back(mk(1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001101)); // 21 issue rd4 #1
    tbl.push_back(mk(1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001111)); // 22 issue rd4 #2
    tbl.push_back(mk(1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001111)); // 23 issue rd4 #3
    tbl.push_back(mk(0, 0, 0, 4, 2'b01, 4, 0, 0, 0, 1, 7'b1101111)); // 24 one wb, no bypass
    tbl.push_back(mk(0, 0, 4, 4, 2'b11, 4, 4, 0, 0, 1, 7'b1001111)); // 25 both ports wb4
    tbl.push_back(mk(0, 0, 4, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001101)); // 26 x4 clean
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 7'b1001001)); // 27 pend 1
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 7'b1001001)); // 28 pend 2
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 7'b1001001)); // 29 pend 3
    tbl.push_back(mk(1, 6, 0, 0, 2'b00, 0, 0, 1, 1, 0, 7'b0000101)); // 30 flush from pend
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 7'b1001001)); // 31 guard, no reflush
    tbl.push_back(mk(0, 0, 6, 0, 2'b00, 0, 0, 0, 0, 0, 7'b1001001)); // 32 rd6 not issued
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 7'b0000101)); // 33 flush from idle
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001101)); // 34 guard
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 7'b1001101)); // 35 to pend
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 7'b1001101)); // 36 squashed
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 7'b1001101)); // 37 idle, no flush

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // asynchronous reset in the middle of PEND with a pending write on x2
    apply(mk(1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001101), 100);
    apply(mk(0, 0, 2, 0, 2'b00, 0, 0, 1, 0, 1, 7'b1011111), 101);
    @(negedge clk);
    #1;
    check("pend_state", 8'(bus.fl_state_o), 8'(FL_PEND));
    check("pend_dirty", 8'(bus.rs_dirty_o), 8'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_state", 8'(bus.fl_state_o), 8'(FL_IDLE));
    check("rst_busy", 8'(bus.busy_o), 8'd0);
    rst = 1'b0;
    bus.redirect_req_i = 1'b0;
    #1;
    check("rst_err", 8'(bus.err_o), 8'd0);
    check("rst_dirty", 8'(bus.rs_dirty_o), 8'd0);
    apply(mk(0, 0, 2, 0, 2'b00, 0, 0, 0, 0, 1, 7'b1001100), 102);
    check("post_state", 8'(bus.fl_state_o), 8'(FL_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
